// File: rtl/fpa_pkg.sv
// Shared definitions for the single-precision adder front end and pack stage.
// Field widths, special-result encodings and the IEEE-754 word unpacker.
package fpa_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int WORD_W  = 1 + EXP_W + MAN_W;
    localparam int SIG_W   = MAN_W + 1;
    localparam int ALIGN_W = MAN_W + 4;
    localparam int SHAMT_W = EXP_W;
    localparam int BIAS    = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        SPC_NONE = 2'b00,
        SPC_NAN  = 2'b01,
        SPC_INF  = 2'b10
    } spc_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] man;
        logic             is_nan;
        logic             is_inf;
    } operand_t;

    // Subnormals flush to zero: the hidden bit is only set for a nonzero exponent.
    function automatic operand_t unpack_word(input logic [WORD_W-1:0] w);
        operand_t         o;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e        = w[WORD_W-2 -: EXP_W];
        f        = w[MAN_W-1:0];
        o.sign   = w[WORD_W-1];
        o.exp    = e;
        o.man    = (e == '0) ? '0 : {1'b1, f};
        o.is_inf = (e == EXP_MAX) && (f == '0);
        o.is_nan = (e == EXP_MAX) && (f != '0);
        return o;
    endfunction

endpackage

// File: rtl/fpa_align_shift.sv
// Right shift with sticky collection; saturates to a lone sticky bit once the
// shift amount reaches the operand width. Shared with the normaliser.
module fpa_align_shift
    import fpa_pkg::*;
#(
    parameter int W    = ALIGN_W,
    parameter int SH_W = SHAMT_W
) (
    input  logic [W-1:0]    val,
    input  logic [SH_W-1:0] amt,
    output logic [W-1:0]    res
);

    localparam logic [SH_W-1:0] SAT_AMT = SH_W'(W);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;

    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        res       = '0;
        if (amt >= SAT_AMT) begin
            res = {{(W-1){1'b0}}, |val};
        end else begin
            shifted   = val >> amt;
            lost_mask = ~({W{1'b1}} << amt);
            res       = {shifted[W-1:1], shifted[0] | (|(val & lost_mask))};
        end
    end

endmodule

// File: rtl/fpa_operand_unpack.sv
// Adder front end: stage 1 unpacks and classifies both operands, stage 2
// orders them by magnitude, aligns the smaller mantissa and resolves specials.
module fpa_operand_unpack
    import fpa_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_a,
    input  logic [WORD_W-1:0]   in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign_l,
    output logic                out_sign_s,
    output logic [EXP_W-1:0]    out_exp,
    output logic [SIG_W-1:0]    out_man_l,
    output logic [ALIGN_W-1:0]  out_man_s,
    output logic                out_eff_sub,
    output logic                out_swap,
    output logic [1:0]          out_special
);

    logic     v1_q, v1_d;
    logic     v2_q, v2_d;
    operand_t op_a_q, op_a_d;
    operand_t op_b_q, op_b_d;

    logic               sign_l_q, sign_l_d;
    logic               sign_s_q, sign_s_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [SIG_W-1:0]   man_l_q, man_l_d;
    logic [ALIGN_W-1:0] man_s_q, man_s_d;
    logic               eff_sub_q, eff_sub_d;
    logic               swap_q, swap_d;
    spc_e               special_q, special_d;

    logic ld1;
    logic ld2;

    // A stage may refill in the same cycle that its successor drains.
    assign in_ready = !v1_q || !v2_q || out_ready;
    assign ld1      = in_valid && in_ready;
    assign ld2      = v1_q && (!v2_q || out_ready);

    always_comb begin
        v1_d   = v1_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (ld1) begin
            v1_d   = 1'b1;
            op_a_d = unpack_word(in_a);
            op_b_d = unpack_word(in_b);
        end else if (ld2) begin
            v1_d = 1'b0;
        end
    end

    logic               swap_c;
    operand_t           op_l;
    operand_t           op_s;
    logic [EXP_W-1:0]   diff_c;
    logic [ALIGN_W-1:0] man_s_c;
    logic               nan_c;
    logic               inf_c;
    spc_e               special_c;
    logic               sign_l_c;

    always_comb begin
        swap_c = {op_a_q.exp, op_a_q.man} < {op_b_q.exp, op_b_q.man};
        op_l   = swap_c ? op_b_q : op_a_q;
        op_s   = swap_c ? op_a_q : op_b_q;
        diff_c = op_l.exp - op_s.exp;
        nan_c  = op_a_q.is_nan || op_b_q.is_nan
              || (op_a_q.is_inf && op_b_q.is_inf && (op_a_q.sign != op_b_q.sign));
        inf_c  = op_a_q.is_inf || op_b_q.is_inf;
        if (nan_c) begin
            special_c = SPC_NAN;
            sign_l_c  = op_l.sign;
        end else if (inf_c) begin
            special_c = SPC_INF;
            sign_l_c  = op_a_q.is_inf ? op_a_q.sign : op_b_q.sign;
        end else begin
            special_c = SPC_NONE;
            sign_l_c  = op_l.sign;
        end
    end

    fpa_align_shift #(
        .W    (ALIGN_W),
        .SH_W (SHAMT_W)
    ) u_align (
        .val (({op_s.man, 3'b000})),
        .amt (diff_c),
        .res (man_s_c)
    );

    always_comb begin
        v2_d      = v2_q;
        sign_l_d  = sign_l_q;
        sign_s_d  = sign_s_q;
        exp_d     = exp_q;
        man_l_d   = man_l_q;
        man_s_d   = man_s_q;
        eff_sub_d = eff_sub_q;
        swap_d    = swap_q;
        special_d = special_q;
        if (ld2) begin
            v2_d      = 1'b1;
            sign_l_d  = sign_l_c;
            sign_s_d  = op_s.sign;
            exp_d     = op_l.exp;
            man_l_d   = op_l.man;
            man_s_d   = man_s_c;
            eff_sub_d = op_a_q.sign ^ op_b_q.sign;
            swap_d    = swap_c;
            special_d = special_c;
        end else if (out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sign_l_q  <= 1'b0;
            sign_s_q  <= 1'b0;
            exp_q     <= '0;
            man_l_q   <= '0;
            man_s_q   <= '0;
            eff_sub_q <= 1'b0;
            swap_q    <= 1'b0;
            special_q <= SPC_NONE;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sign_l_q  <= sign_l_d;
            sign_s_q  <= sign_s_d;
            exp_q     <= exp_d;
            man_l_q   <= man_l_d;
            man_s_q   <= man_s_d;
            eff_sub_q <= eff_sub_d;
            swap_q    <= swap_d;
            special_q <= special_d;
        end
    end

    assign out_valid   = v2_q;
    assign out_sign_l  = sign_l_q;
    assign out_sign_s  = sign_s_q;
    assign out_exp     = exp_q;
    assign out_man_l   = man_l_q;
    assign out_man_s   = man_s_q;
    assign out_eff_sub = eff_sub_q;
    assign out_swap    = swap_q;
    assign out_special = special_q;

endmodule

// File: doc/fpa_operand_unpack.md
Name: fpa_operand_unpack

Overview:
Front end of the pipelined single-precision floating-point adder. It is the inverse of the result-pack stage, which assembles sign, exponent and mantissa into a 32-bit word; this block takes two IEEE-754 words apart instead.
- Unpacks both operands and classifies special values.
- Orders the operands by magnitude and aligns the smaller mantissa with guard, round and sticky bits.
- Two register stages with a valid/ready handshake, so the adder core can apply backpressure.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa field width (word width = 1+EXP_W+MAN_W = 32)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept the pair this cycle
in_a  in  32  operand A, IEEE-754
in_b  in  32  operand B, IEEE-754
out_valid  out  1  aligned pair valid
out_ready  in  1  core accepts the pair
out_sign_l  out  1  sign of the larger-magnitude operand
out_sign_s  out  1  sign of the smaller-magnitude operand
out_exp  out  8  exponent of the larger operand (result exponent before normalisation)
out_man_l  out  24  larger mantissa, hidden bit included
out_man_s  out  27  smaller mantissa {hidden,23 frac,G,R,S} after right shift
out_eff_sub  out  1  effective subtract (sign_a ^ sign_b)
out_swap  out  1  1 when B is the larger operand
out_special  out  2  00 normal, 01 NaN result, 10 infinity result (sign on out_sign_l), 11 unused

Behaviour:
Reset:
- Both stage valid bits and all data registers are 0.
- out_valid=0, all outputs 0; in_ready=1 after reset.

Handshake:
- Each stage has its own valid bit. A stage may load when it is empty or when the stage after it drains in the same cycle.
- in_ready = !v1 | !v2 | out_ready (combinational).
- A transfer occurs on in_valid & in_ready; output transfer occurs on out_valid & out_ready.
- Latency is 2 clocks. Throughput is one pair per clock while out_ready=1.
- While out_valid=1 and out_ready=0, all out_* signals are held stable.
- No pair is dropped or duplicated; order is preserved.

Stage 1 (unpack):
- Register sign, exponent and 24-bit mantissa for each operand.
- exp==0 is flushed to zero: mantissa 0, no hidden bit.
- exp==all-ones: mantissa 0 means inf, otherwise NaN.
- Record class flags per operand.

Stage 2 (order and align):
- Compare {exp,man}. The larger operand goes to L.
- On equal magnitude, A is L and out_swap=0.
- d = exp_L - exp_S (unsigned, 8 bits).
- If d<27: out_man_s = ({man_S,3'b0} >> d), with bit0 ORed with the OR of all bits shifted out.
- If d>=27: out_man_s = {26'b0, |man_S}.
- d=0: no shift, sticky=0.

Specials (evaluated in stage 2):
- out_special=01 if either operand is NaN, or if inf+inf with opposite signs.
- Otherwise 10 if either operand is inf; out_sign_l is the sign of the inf.
- Specials pass through with the same latency and handshake; data fields are don't-care but deterministic.

Reset mid-operation: the next clock edge with rst=0 clears both valid bits; in-flight pairs are discarded.

Decomposition:
- Package fpa_pkg holds: EXP_W, MAN_W, BIAS=127, EXP_MAX, SPC_NONE/SPC_NAN/SPC_INF encodings, and the aligned-width localparam (MAN_W+4). The pack stage shares this package.
- One sub-module, fpa_align_shift: combinational right shift of a 27-bit value by an 8-bit amount, producing the sticky bit and saturating at d>=27. It is reused by the normaliser.

Test Plan:
1. a=0x3F800000 (1.0), b=0x40000000 (2.0), out_ready=1 -> two clocks later:
   - out_swap=1, out_exp=0x80, out_man_l=0x800000, out_man_s=0x2000000
   - out_eff_sub=0, out_special=00
2. a=0x4B800000, b=0x3F800001 (d=24) -> out_man_s=0x0000005 (shifted value 4, sticky set), out_swap=0.
3. a=0x3F800000, b=0x4E800000 (d=30) -> out_man_s=0x0000001, out_exp=0x9D, out_swap=1.
4. Specials:
   - a=0x7FC00000, b=0x3F800000 -> out_special=01.
   - a=0x7F800000, b=0xFF800000 -> out_special=01.
   - a=0xFF800000, b=0x3F800000 -> out_special=10, out_sign_l=1.
5. Backpressure:
   - Stimulus: issue three back-to-back pairs with out_ready=0 for 4 clocks.
   - in_ready drops after two accepted pairs; outputs stay stable.
   - After out_ready=1, all three pairs emerge in order with no loss.
6. Reset mid-operation:
   - Stimulus: rst=0 for one clock with both stages full.
   - Next clock: out_valid=0, in_ready=1, all outputs 0.
   - The first pair after reset appears exactly 2 clocks after it is accepted.
